irq_pend_ctrl: RTL and testbench

Eight-channel interrupt pending controller that sits directly upstream of the 8-to-3 priority encoder. It detects rising edges on eight request lines and latches them as pending. It applies a per-channel enable and drives the masked pending vector into the encoder's 8-bit input. It raises a single interrupt line, which the consumer retires with an acknowledge carrying the encoder's 3-bit channel code; a programmable hold-off follows each acknowledge.

---
 rtl/irq_pend_ctrl.sv | 120 ++++++++++++
 tb/tb_irq_pend_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/irq_pend_ctrl.sv
// irq_pend_ctrl: eight-channel interrupt pending controller.
// Latches rising edges per channel and masks them with a per-channel enable.
// It raises irq while any visible bit is pending and retires one channel
// per acknowledge, followed by a programmable hold-off.

// Per-channel slice: edge detect, pending latch, enable bit, sticky overflow.
module irq_pend_lane (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic en_wr,
  input  logic en_bit,
  input  logic clr,
  input  logic ovf_clr,
  output logic pend_vis,
  output logic ovf
);
  logic req_q, pend, en, rise;

  assign rise = req & ~req_q;

  // req_q resets high, so a line already high at reset release is not an event.
  // A new rise wins over a same-cycle clear. An overflow set wins over ovf_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= 1'b1;
      pend  <= 1'b0;
      en    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      req_q <= req;
      pend  <= (pend & ~clr) | rise;
      if (en_wr) en <= en_bit;
      if (rise & pend & ~clr) ovf <= 1'b1;
      else if (ovf_clr)       ovf <= 1'b0;
    end
  end

  assign pend_vis = pend & en;
endmodule

module irq_pend_ctrl #(
  parameter int HOLDOFF = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_in,
  input  logic       en_wr,
  input  logic [7:0] en_in,
  input  logic       ack,
  input  logic [2:0] ack_id,
  input  logic       ovf_clr,
  output logic [7:0] pend_vec,
  output logic       irq,
  output logic [7:0] ovf
);
  localparam int NUM_LANES = 8;

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_HOLD} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       ack_acc;
  logic [7:0] clr;

  // Only an ack seen in ASSERT retires a channel.
  assign ack_acc = ack && (state == S_ASSERT);
  assign clr     = ack_acc ? (8'b1 << ack_id) : 8'b0;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    irq_pend_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .req      (req_in[i]),
      .en_wr    (en_wr),
      .en_bit   (en_in[i]),
      .clr      (clr[i]),
      .ovf_clr  (ovf_clr),
      .pend_vis (pend_vec[i]),
      .ovf      (ovf[i])
    );
  end

  // FSM state and hold-off counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: assert on visible pending; after an ack, count down the hold-off.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE:
        if (|pend_vec) state_nxt = S_ASSERT;
      S_ASSERT:
        if (ack) begin
          if (HOLDOFF == 0) state_nxt = S_IDLE;
          else begin
            state_nxt = S_HOLD;
            cnt_nxt   = 4'(HOLDOFF - 1);
          end
        end else if (pend_vec == 8'd0) begin
          state_nxt = S_IDLE;
        end
      S_HOLD:
        if (cnt == 4'd0) state_nxt = S_IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign irq = (state == S_ASSERT);
endmodule

// File: tb/tb_irq_pend_ctrl.sv
// Randomized bench for irq_pend_ctrl against a timestamp-based reference model.
module tb_irq_pend_ctrl;
  localparam int HO = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_in, en_in, pend_vec, ovf;
  logic       en_wr, ack, ovf_clr, irq;
  logic [2:0] ack_id;

  irq_pend_ctrl #(.HOLDOFF(HO)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .en_wr(en_wr), .en_in(en_in),
    .ack(ack), .ack_id(ack_id), .ovf_clr(ovf_clr),
    .pend_vec(pend_vec), .irq(irq), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: bit vectors plus the edge index at which the
  // controller is next allowed to raise irq.
  logic [7:0] rq_m, pend_m, en_m, ovf_m;
  logic       irq_m;
  int         cyc, idle_at;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [7:0] r, input logic ew, input logic [7:0] ei,
                            input logic a, input logic [2:0] aid, input logic oc,
                            input logic rs);
    logic [7:0] pv, rise, clr;
    if (rs) begin
      rq_m = 8'hFF; pend_m = 8'h00; en_m = 8'h00; ovf_m = 8'h00;
      irq_m = 1'b0; idle_at = cyc;
    end else begin
      pv   = pend_m & en_m;
      rise = r & ~rq_m;
      clr  = (irq_m && a) ? (8'd1 << aid) : 8'd0;
      ovf_m  = (oc ? 8'h00 : ovf_m) | (rise & pend_m & ~clr);
      pend_m = (pend_m & ~clr) | rise;
      if (irq_m) begin
        if (a) begin irq_m = 1'b0; idle_at = cyc + HO; end
        else if (pv == 8'h00) begin irq_m = 1'b0; idle_at = cyc; end
      end else if (cyc > idle_at && pv != 8'h00) begin
        irq_m = 1'b1;
      end
      rq_m = r;
      if (ew) en_m = ei;
    end
    cyc++;
  endtask

  // Drive one cycle of inputs, advance DUT and model, then compare.
  task automatic step(input logic [7:0] r, input logic ew, input logic [7:0] ei,
                      input logic a, input logic [2:0] aid, input logic oc,
                      input logic rs);
    req_in = r; en_wr = ew; en_in = ei; ack = a; ack_id = aid; ovf_clr = oc; rst = rs;
    @(posedge clk);
    model_edge(r, ew, ei, a, aid, oc, rs);
    @(negedge clk);
    chk("pend_vec", {24'd0, pend_vec}, {24'd0, pend_m & en_m});
    chk("irq",      {31'd0, irq},      {31'd0, irq_m});
    chk("ovf",      {24'd0, ovf},      {24'd0, ovf_m});
  endtask

  function automatic logic [2:0] top_bit(input logic [7:0] v);
    logic [2:0] id = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) id = 3'(i);
    return id;
  endfunction

  logic [7:0] r_cur, pv_m;
  logic [2:0] aid_r;

  initial begin
    cyc = 0; idle_at = 0;
    rq_m = 8'hFF; pend_m = 8'h00; en_m = 8'h00; ovf_m = 8'h00; irq_m = 1'b0;
    req_in = 8'h81; en_wr = 1'b0; en_in = 8'h00; ack = 1'b0; ack_id = 3'd0;
    ovf_clr = 1'b0; rst = 1'b1;
    @(negedge clk);

    // Reset with lines already high: no events after release.
    step(8'h81, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1);
    step(8'h81, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1);
    chk("rst_pend_vec", {24'd0, pend_vec}, 32'h0);
    chk("rst_irq",      {31'd0, irq},      32'h0);
    chk("rst_ovf",      {24'd0, ovf},      32'h0);
    step(8'h81, 1'b1, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(8'h81, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("held_no_evt_pv",  {24'd0, pend_vec}, 32'h0);
    chk("held_no_evt_irq", {31'd0, irq},      32'h0);

    // Single pulse on channel 5, then ack it.
    step(8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    step(8'h20, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("ch5_pv_k",  {24'd0, pend_vec}, 32'h20);
    chk("ch5_irq_k", {31'd0, irq},      32'h0);
    step(8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("ch5_irq_k1", {31'd0, irq}, 32'h1);
    step(8'h00, 1'b0, 8'h00, 1'b1, 3'd5, 1'b0, 1'b0);
    chk("ch5_ack_pv",  {24'd0, pend_vec}, 32'h0);
    chk("ch5_ack_irq", {31'd0, irq},      32'h0);
    for (int i = 0; i < 5; i++) step(8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("ch5_no_reassert", {31'd0, irq}, 32'h0);

    // Randomized traffic: sparse edges, frequent acks aimed at the top pending bit.
    r_cur = 8'h00;
    for (int n = 0; n < 4000; n++) begin
      logic [7:0] r_nxt, ei;
      logic ew, a, oc, rs;
      r_nxt = r_cur;
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 9) == 0) r_nxt[b] = ~r_nxt[b];
      ew = ($urandom_range(0, 19) == 0);
      ei = 8'($urandom);
      a  = ($urandom_range(0, 2) == 0);
      oc = ($urandom_range(0, 14) == 0);
      rs = ($urandom_range(0, 499) == 0);
      pv_m  = pend_m & en_m;
      aid_r = ($urandom_range(0, 3) != 0) ? top_bit(pv_m) : 3'($urandom);
      step(r_nxt, ew, ei, a, aid_r, oc, rs);
      r_cur = r_nxt;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
